// File: rtl/addr_gen_unit.sv
// Address generation unit: base + or - an extended, optionally shifted IR offset field.
// The result is registered behind a single-entry valid/ready output stage with range-wrap flagging.
module addr_gen_unit #(
    parameter int DATA_W = 16,
    parameter int IR_W   = 11
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [1:0]        i_BaseSel,
    input  logic [2:0]        i_OffSel,
    input  logic              i_Lshf1,
    input  logic              i_Sub,
    input  logic [IR_W-1:0]   i_IR_10_0,
    input  logic [DATA_W-1:0] i_PC,
    input  logic [DATA_W-1:0] i_SR1_Out,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [DATA_W-1:0] o_Addr,
    output logic              o_Wrap
);

    localparam int OW = DATA_W + 1;
    localparam int RW = DATA_W + 2;

    function automatic logic signed [OW-1:0] form_offset(
        input logic [2:0]      sel,
        input logic [IR_W-1:0] ir,
        input logic            lshf
    );
        logic signed [OW-1:0] ext;
        ext = '0;
        case (sel)
            3'b001:  ext = {{(OW-6){ir[5]}}, ir[5:0]};
            3'b010:  ext = {{(OW-9){ir[8]}}, ir[8:0]};
            3'b011:  ext = {{(OW-11){ir[10]}}, ir[10:0]};
            3'b100:  ext = {{(OW-8){1'b0}}, ir[7:0]};
            default: ext = '0;
        endcase
        if (lshf) begin
            ext = {ext[OW-2:0], 1'b0};
        end
        return ext;
    endfunction

    // Negative (top bit) or at/above 2^DATA_W (next bit) means the address left the space.
    function automatic logic out_of_range(input logic signed [RW-1:0] r);
        return r[RW-1] | r[RW-2];
    endfunction

    logic [DATA_W-1:0]    addr_p0;
    logic                 wrap_p0;
    logic                 vld_p0;

    logic [DATA_W-1:0]    base;
    logic signed [OW-1:0] offset;
    logic signed [RW-1:0] base_x;
    logic signed [RW-1:0] off_x;
    logic signed [RW-1:0] result;
    logic                 accept;

    // Input stage: base select, offset formation, add/subtract.
    // addr_p0 only ever loads on accept, so it doubles as the LAST register.
    always_comb begin
        base = '0;
        case (i_BaseSel)
            2'b00:   base = i_PC;
            2'b01:   base = i_SR1_Out;
            2'b10:   base = '0;
            default: base = addr_p0;
        endcase
    end

    assign offset = form_offset(i_OffSel, i_IR_10_0, i_Lshf1);
    assign base_x = signed'({2'b00, base});
    assign off_x  = {offset[OW-1], offset};
    assign result = i_Sub ? (base_x - off_x) : (base_x + off_x);

    assign o_Ready = !vld_p0 || i_Ready;
    assign accept  = i_Valid && o_Ready;

    // Output stage: single-entry register, refilled in the same cycle it drains.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
            wrap_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            addr_p0 <= result[DATA_W-1:0];
            wrap_p0 <= out_of_range(result);
        end else if (i_Ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign o_Valid = vld_p0;
    assign o_Addr  = addr_p0;
    assign o_Wrap  = wrap_p0;

endmodule

// File: tb/tb_addr_gen_unit.sv
// Bench for addr_gen_unit: directed vector table, LAST chaining, backpressure, reset and
// randomized traffic compared against an integer-arithmetic model of the address rules.
module tb_addr_gen_unit;

    localparam int DW = 16;

    logic          i_Clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Valid = 1'b0;
    logic          o_Ready;
    logic [1:0]    i_BaseSel = '0;
    logic [2:0]    i_OffSel = '0;
    logic          i_Lshf1 = 1'b0;
    logic          i_Sub = 1'b0;
    logic [10:0]   i_IR_10_0 = '0;
    logic [DW-1:0] i_PC = '0;
    logic [DW-1:0] i_SR1_Out = '0;
    logic          o_Valid;
    logic          i_Ready = 1'b1;
    logic [DW-1:0] o_Addr;
    logic          o_Wrap;

    int checks = 0;
    int errors = 0;

    addr_gen_unit #(.DATA_W(DW), .IR_W(11)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_BaseSel(i_BaseSel), .i_OffSel(i_OffSel), .i_Lshf1(i_Lshf1), .i_Sub(i_Sub),
        .i_IR_10_0(i_IR_10_0), .i_PC(i_PC), .i_SR1_Out(i_SR1_Out), .o_Valid(o_Valid),
        .i_Ready(i_Ready), .o_Addr(o_Addr), .o_Wrap(o_Wrap)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [1:0]  bsel;
        logic [2:0]  osel;
        logic        lshf;
        logic        sub;
        logic [10:0] ir;
        logic [15:0] pc;
        logic [15:0] sr1;
        logic [15:0] eaddr;
        logic        ewrap;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] bsel, input logic [2:0] osel, input logic lshf,
                         input logic sub, input logic [10:0] ir, input logic [15:0] pc,
                         input logic [15:0] sr1);
        i_BaseSel = bsel; i_OffSel = osel; i_Lshf1 = lshf; i_Sub = sub;
        i_IR_10_0 = ir; i_PC = pc; i_SR1_Out = sr1;
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    // Reference model: integer arithmetic straight from the address rules.
    function automatic int ref_offset(input logic [2:0] osel, input logic [10:0] ir, input logic lshf);
        int v;
        case (osel)
            3'd1: begin v = int'(ir[5:0]);  if (v >= 32)   v -= 64;   end
            3'd2: begin v = int'(ir[8:0]);  if (v >= 256)  v -= 512;  end
            3'd3: begin v = int'(ir[10:0]); if (v >= 1024) v -= 2048; end
            3'd4: v = int'(ir[7:0]);
            default: v = 0;
        endcase
        if (lshf) v = v * 2;
        return v;
    endfunction

    bit          m_vld;
    logic [15:0] m_addr;
    logic        m_wrap;
    logic [15:0] m_last;

    task automatic model_accept(input logic [1:0] bsel, input logic [2:0] osel, input logic lshf,
                                input logic sub, input logic [10:0] ir, input logic [15:0] pc,
                                input logic [15:0] sr1);
        int b;
        int r;
        case (bsel)
            2'd0: b = int'(pc);
            2'd1: b = int'(sr1);
            2'd2: b = 0;
            default: b = int'(m_last);
        endcase
        r = sub ? b - ref_offset(osel, ir, lshf) : b + ref_offset(osel, ir, lshf);
        m_vld  = 1'b1;
        m_wrap = (r < 0) || (r >= 65536);
        m_addr = 16'(r & 32'hFFFF);
        m_last = m_addr;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 3'd2, 1'b0, 1'b0, 11'h1FF, 16'h3000, 16'h0000, 16'h2FFF, 1'b0};
        vecs[1]  = '{2'd1, 3'd1, 1'b1, 1'b0, 11'h020, 16'h0000, 16'h4000, 16'h3FC0, 1'b0};
        vecs[2]  = '{2'd2, 3'd4, 1'b0, 1'b0, 11'h025, 16'h1111, 16'h2222, 16'h0025, 1'b0};
        vecs[3]  = '{2'd0, 3'd2, 1'b0, 1'b0, 11'h1FF, 16'h0000, 16'h0000, 16'hFFFF, 1'b1};
        vecs[4]  = '{2'd0, 3'd1, 1'b0, 1'b0, 11'h001, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{2'd1, 3'd1, 1'b0, 1'b1, 11'h001, 16'h0000, 16'h0010, 16'h000F, 1'b0};
        vecs[6]  = '{2'd0, 3'd5, 1'b1, 1'b0, 11'h7FF, 16'h1234, 16'h0000, 16'h1234, 1'b0};
        vecs[7]  = '{2'd2, 3'd3, 1'b1, 1'b0, 11'h400, 16'h0000, 16'h0000, 16'hF800, 1'b1};
        vecs[8]  = '{2'd0, 3'd4, 1'b1, 1'b0, 11'h0FF, 16'h0100, 16'h0000, 16'h02FE, 1'b0};
        vecs[9]  = '{2'd1, 3'd1, 1'b0, 1'b1, 11'h03F, 16'h0000, 16'hFFF0, 16'hFFF1, 1'b0};
        vecs[10] = '{2'd1, 3'd1, 1'b0, 1'b1, 11'h03F, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
        vecs[11] = '{2'd2, 3'd3, 1'b0, 1'b0, 11'h3FF, 16'h0000, 16'h0000, 16'h03FF, 1'b0};
        vecs[12] = '{2'd0, 3'd1, 1'b0, 1'b0, 11'h7C1, 16'h0005, 16'h0000, 16'h0006, 1'b0};

        // Reset state
        #2;
        check("rst_valid", o_Valid, 0);
        check("rst_addr", o_Addr, 0);
        check("rst_wrap", o_Wrap, 0);
        check("rst_ready", o_Ready, 1);
        #8 i_Rst_n = 1'b1;
        step();

        // Directed vector table, back-to-back with the consumer always ready
        i_Ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].bsel, vecs[i].osel, vecs[i].lshf, vecs[i].sub, vecs[i].ir,
                  vecs[i].pc, vecs[i].sr1);
            i_Valid = 1'b1;
            step();
            check($sformatf("vec%0d_valid", i), o_Valid, 1);
            check($sformatf("vec%0d_addr", i), o_Addr, vecs[i].eaddr);
            check($sformatf("vec%0d_wrap", i), o_Wrap, vecs[i].ewrap);
        end

        // Chained LAST, three back-to-back requests
        drive(2'd0, 3'd1, 1'b0, 1'b0, 11'h002, 16'h3000, 16'h0000);
        step();
        check("chain0_valid", o_Valid, 1);
        check("chain0_addr", o_Addr, 16'h3002);
        drive(2'd3, 3'd1, 1'b0, 1'b0, 11'h002, 16'h7777, 16'h0000);
        step();
        check("chain1_valid", o_Valid, 1);
        check("chain1_addr", o_Addr, 16'h3004);
        drive(2'd3, 3'd1, 1'b0, 1'b1, 11'h004, 16'h7777, 16'h0000);
        step();
        check("chain2_valid", o_Valid, 1);
        check("chain2_addr", o_Addr, 16'h3000);
        check("chain2_wrap", o_Wrap, 0);
        i_Valid = 1'b0;
        step();
        check("drain_valid", o_Valid, 0);

        // Backpressure: first result held, second accepted the cycle i_Ready rises
        drive(2'd0, 3'd1, 1'b0, 1'b0, 11'h001, 16'h1000, 16'h0000);
        i_Valid = 1'b1;
        i_Ready = 1'b0;
        step();
        drive(2'd0, 3'd1, 1'b0, 1'b0, 11'h002, 16'h2000, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_valid", c), o_Valid, 1);
            check($sformatf("bp%0d_addr", c), o_Addr, 16'h1001);
            check($sformatf("bp%0d_ready", c), o_Ready, 0);
            step();
        end
        i_Ready = 1'b1;
        #1;
        check("bp_ready_rise", o_Ready, 1);
        step();
        check("bp_second_valid", o_Valid, 1);
        check("bp_second_addr", o_Addr, 16'h2002);
        i_Valid = 1'b0;
        step();
        check("bp_drain_valid", o_Valid, 0);

        // Reset while a result is pending
        drive(2'd0, 3'd1, 1'b0, 1'b0, 11'h002, 16'h3000, 16'h0000);
        i_Valid = 1'b1;
        i_Ready = 1'b0;
        step();
        i_Valid = 1'b0;
        check("pre_rst_addr", o_Addr, 16'h3002);
        #3 i_Rst_n = 1'b0;
        #1;
        check("midrst_valid", o_Valid, 0);
        check("midrst_addr", o_Addr, 0);
        check("midrst_ready", o_Ready, 1);
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        i_Ready = 1'b1;
        drive(2'd3, 3'd0, 1'b0, 1'b0, 11'h7FF, 16'h5555, 16'h6666);
        i_Valid = 1'b1;
        step();
        check("post_rst_last_valid", o_Valid, 1);
        check("post_rst_last_addr", o_Addr, 0);
        check("post_rst_last_wrap", o_Wrap, 0);

        // Randomized traffic against the model, starting from a fresh reset
        i_Valid = 1'b0;
        i_Rst_n = 1'b0;
        #2 i_Rst_n = 1'b1;
        m_vld = 1'b0; m_addr = '0; m_wrap = 1'b0; m_last = '0;
        for (int n = 0; n < 400; n++) begin
            bit acc;
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), 11'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
            i_Valid = 1'($urandom_range(0, 3) != 0);
            i_Ready = 1'($urandom_range(0, 3) != 0);
            #1;
            check("rnd_ready", o_Ready, (!m_vld || i_Ready));
            acc = i_Valid && (!m_vld || i_Ready);
            @(posedge i_Clk);
            if (acc) model_accept(i_BaseSel, i_OffSel, i_Lshf1, i_Sub, i_IR_10_0, i_PC, i_SR1_Out);
            else if (i_Ready) m_vld = 1'b0;
            #1;
            check("rnd_valid", o_Valid, m_vld);
            if (m_vld) begin
                check("rnd_addr", o_Addr, m_addr);
                check("rnd_wrap", o_Wrap, m_wrap);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
